// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution for the mov/branch decode stage.
// Optional build macro BRANCH_COUNT_EN adds a saturating taken-branch counter output.
module pc_branch_unit #(
    parameter int WIDTH    = 8,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instrValid,
    input  logic             bcf,
    input  logic             bbf,
    input  logic             buc,
    input  logic             toggleOut,
    input  logic [WIDTH-1:0] r3,
    input  logic             carryFlag,
    input  logic             borrowFlag,
    output logic [WIDTH-1:0] pc,
    output logic             pcRedirect,
    output logic             outSel,
    output logic [WIDTH-1:0] pinsOut,
`ifdef BRANCH_COUNT_EN
    output logic [WIDTH-1:0] branchCount,
`endif
    output logic             halted
);

    typedef enum logic {RUN, HALT} stateT;

    stateT state;

    logic             bucWin;
    logic             bcfWin;
    logic             bbfWin;
    logic             toggleWin;
    logic             taken;
    logic             offsetZero;
    logic [WIDTH-1:0] pcInc;
    logic [WIDTH-1:0] pcBranch;

    // Strobes should be one-hot; a fixed priority makes sure exactly one of them acts.
    always_comb begin
        bucWin     = buc;
        bcfWin     = !buc && bcf;
        bbfWin     = !buc && !bcf && bbf;
        toggleWin  = !buc && !bcf && !bbf && toggleOut;
        taken      = bucWin || (bcfWin && carryFlag) || (bbfWin && borrowFlag);
        offsetZero = (r3 == '0);
        pcInc      = pc + WIDTH'(1);
        pcBranch   = pc + r3;
    end

    assign pinsOut = outSel ? r3 : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= WIDTH'(RESET_PC);
            pcRedirect <= 1'b0;
            outSel     <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    pcRedirect <= 1'b0;
                    if (instrValid) begin
                        if (taken) begin
                            pcRedirect <= 1'b1;
                            pc         <= pcBranch;
                            // A zero-offset unconditional branch is the program's halt idiom.
                            if (bucWin && offsetZero) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                        end else begin
                            pc <= pcInc;
                            if (toggleWin) begin
                                outSel <= !outSel;
                            end
                        end
                    end
                end
                HALT: begin
                    pcRedirect <= 1'b0;
                    halted     <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef BRANCH_COUNT_EN
    // Counts every taken branch, halting ones included, and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            branchCount <= '0;
        end else if (state == RUN && instrValid && taken && branchCount != '1) begin
            branchCount <= branchCount + WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard testbench for pc_branch_unit: directed vectors push hand-computed results,
// a monitor pops and compares them one cycle after each accepting edge.
module tb_pc_branch_unit;

    logic       clk;
    logic       rst;
    logic       instrValid;
    logic       bcf;
    logic       bbf;
    logic       buc;
    logic       toggleOut;
    logic [7:0] r3;
    logic       carryFlag;
    logic       borrowFlag;
    logic [7:0] pc;
    logic       pcRedirect;
    logic       outSel;
    logic [7:0] pinsOut;
    logic       halted;
`ifdef BRANCH_COUNT_EN
    logic [7:0] branchCount;
`endif

    typedef struct {
        string      name;
        logic [7:0] pc;
        logic       red;
        logic       sel;
        logic [7:0] pins;
        logic       halt;
        logic [7:0] cnt;
    } expT;

    expT        scoreQ[$];
    int         testsRun;
    int         testsFailed;
    logic [7:0] expCnt;

    pc_branch_unit #(.WIDTH(8), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .instrValid (instrValid),
        .bcf        (bcf),
        .bbf        (bbf),
        .buc        (buc),
        .toggleOut  (toggleOut),
        .r3         (r3),
        .carryFlag  (carryFlag),
        .borrowFlag (borrowFlag),
        .pc         (pc),
        .pcRedirect (pcRedirect),
        .outSel     (outSel),
        .pinsOut    (pinsOut),
`ifdef BRANCH_COUNT_EN
        .branchCount(branchCount),
`endif
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    // Drives one instruction on the falling edge and queues the state expected after the next rising edge.
    task automatic applyStimulus(input string name, input logic r, input logic v,
                                 input logic bucI, input logic bcfI, input logic bbfI, input logic togI,
                                 input logic [7:0] r3I, input logic c, input logic b,
                                 input logic [7:0] ePc, input logic eRed, input logic eSel, input logic eHalt);
        expT e;
        @(negedge clk);
        rst        = r;
        instrValid = v;
        buc        = bucI;
        bcf        = bcfI;
        bbf        = bbfI;
        toggleOut  = togI;
        r3         = r3I;
        carryFlag  = c;
        borrowFlag = b;
        if (r)
            expCnt = 8'h00;
        else if (eRed && expCnt != 8'hFF)
            expCnt = expCnt + 8'h01;
        e.name = name;
        e.pc   = ePc;
        e.red  = eRed;
        e.sel  = eSel;
        e.pins = eSel ? r3I : ePc;
        e.halt = eHalt;
        e.cnt  = expCnt;
        scoreQ.push_back(e);
    endtask

    // Monitor: compares one queued expectation shortly after every rising edge.
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                checkOutput({e.name, ".pc"}, pc, e.pc);
                checkOutput({e.name, ".pcRedirect"}, {7'd0, pcRedirect}, {7'd0, e.red});
                checkOutput({e.name, ".outSel"}, {7'd0, outSel}, {7'd0, e.sel});
                checkOutput({e.name, ".pinsOut"}, pinsOut, e.pins);
                checkOutput({e.name, ".halted"}, {7'd0, halted}, {7'd0, e.halt});
`ifdef BRANCH_COUNT_EN
                checkOutput({e.name, ".branchCount"}, branchCount, e.cnt);
`endif
            end
        end
    end

    initial begin
        int waitCycles;
        testsRun    = 0;
        testsFailed = 0;
        expCnt      = 8'h00;
        rst = 1'b1; instrValid = 1'b0; buc = 1'b0; bcf = 1'b0; bbf = 1'b0;
        toggleOut = 1'b0; r3 = 8'h00; carryFlag = 1'b0; borrowFlag = 1'b0;

        //              name          rst v  buc bcf bbf tog r3     c  b   pc     red sel halt
        applyStimulus("reset",        1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        applyStimulus("seq1",         0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h01, 0, 0, 0);
        applyStimulus("seq2",         0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h02, 0, 0, 0);
        applyStimulus("seq3",         0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h03, 0, 0, 0);
        applyStimulus("bucTo10",      0, 1, 1, 0, 0, 0, 8'h0D, 0, 0, 8'h10, 1, 0, 0);
        applyStimulus("bcfTaken",     0, 1, 0, 1, 0, 0, 8'h05, 1, 0, 8'h15, 1, 0, 0);
        applyStimulus("idleHold",     0, 0, 1, 0, 0, 1, 8'h22, 1, 1, 8'h15, 0, 0, 0);
        applyStimulus("bucBackTo10",  0, 1, 1, 0, 0, 0, 8'hFB, 0, 0, 8'h10, 1, 0, 0);
        applyStimulus("bcfNotTaken",  0, 1, 0, 1, 0, 0, 8'h05, 0, 1, 8'h11, 0, 0, 0);
        applyStimulus("bbfTaken",     0, 1, 0, 0, 1, 0, 8'h0F, 0, 1, 8'h20, 1, 0, 0);
        applyStimulus("bucBackWrap",  0, 1, 1, 0, 0, 0, 8'hFE, 0, 0, 8'h1E, 1, 0, 0);
        applyStimulus("bucToFF",      0, 1, 1, 0, 0, 0, 8'hE1, 0, 0, 8'hFF, 1, 0, 0);
        applyStimulus("pcWrap",       0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        applyStimulus("toggleOn",     0, 1, 0, 0, 0, 1, 8'hA5, 0, 0, 8'h01, 0, 1, 0);
        applyStimulus("pinsFollowR3", 0, 1, 0, 0, 0, 0, 8'h3C, 0, 0, 8'h02, 0, 1, 0);
        applyStimulus("toggleOff",    0, 1, 0, 0, 0, 1, 8'h77, 0, 0, 8'h03, 0, 0, 0);
        applyStimulus("bucBeatsBbf",  0, 1, 1, 0, 1, 0, 8'h03, 0, 1, 8'h06, 1, 0, 0);
        applyStimulus("bcfBeatsTog",  0, 1, 0, 1, 0, 1, 8'h00, 0, 0, 8'h07, 0, 0, 0);
        applyStimulus("bcfZeroOff",   0, 1, 0, 1, 0, 0, 8'h00, 1, 0, 8'h07, 1, 0, 0);
        applyStimulus("bcfBeatsBbf",  0, 1, 0, 1, 1, 0, 8'h05, 0, 1, 8'h08, 0, 0, 0);
        applyStimulus("bucTo40",      0, 1, 1, 0, 0, 0, 8'h38, 0, 0, 8'h40, 1, 0, 0);
        applyStimulus("haltEnter",    0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 8'h40, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("haltHold", 0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          8'($urandom), 1'($urandom), 1'($urandom), 8'h40, 0, 0, 1);
        end
        applyStimulus("haltReset",    1, 1, 1, 0, 0, 1, 8'h05, 1, 1, 8'h00, 0, 0, 0);
        applyStimulus("postReset",    0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h01, 0, 0, 0);
`ifdef BRANCH_COUNT_EN
        for (int i = 0; i < 260; i++) begin
            applyStimulus("countSat", 0, 1, 1, 0, 0, 0, 8'h01, 0, 0, 8'(i + 2), 1, 0, 0);
        end
`endif

        waitCycles = 0;
        while (scoreQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        testsRun++;
        if (scoreQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", scoreQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
